// File: rtl/mem_arbiter.sv
// Shares one external memory port between instruction fetch and data access.
// Each pipeline step serves the data access first and the fetch second, and the pipeline stalls until both finish.
module mem_arbiter #(
    parameter int          MAX_WAIT = 255,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ifPc_i,
    input  logic        ifReq_i,
    output logic [31:0] ifInst_o,
    input  logic [31:0] dmemAddr_i,
    input  logic [31:0] dmemWdata_i,
    input  logic [3:0]  dmemRead_i,
    input  logic [2:0]  dmemWrite_i,
    output logic [31:0] dmemRdata_o,
    output logic        busyWait_o,
    output logic        memReq_o,
    output logic [31:0] memAddr_o,
    output logic [31:0] memWdata_o,
    output logic [3:0]  memRead_o,
    output logic [2:0]  memWrite_o,
    input  logic [31:0] memRdata_i,
    input  logic        memAck_i,
    output logic        timeoutErr_o
);

    typedef enum logic [1:0] {
        IDLE,
        D_ACC,
        I_ACC,
        DONE
    } state_t;

    localparam logic [15:0] WAIT_LAST  = 16'(MAX_WAIT - 1);
    localparam logic [3:0]  FETCH_READ = 4'b1010;

    state_t      state_q;
    logic [31:0] pc_q;
    logic        ifReq_q;
    logic [31:0] ifInst_q;
    logic [31:0] rdata_q;
    logic        timeoutErr_q;
    logic [15:0] waitCnt_q;
    logic        memReq_q;
    logic [31:0] memAddr_q;
    logic [31:0] memWdata_q;
    logic [3:0]  memRead_q;
    logic [2:0]  memWrite_q;

    logic dop;
    logic expired;

    assign dop     = dmemRead_i[3] | dmemWrite_i[2];
    assign expired = !memAck_i && (waitCnt_q == WAIT_LAST);

    // Memory-side request registers are loaded on entry to an access state and
    // cleared on leaving it, so MEM_REQ is low whenever the FSM is not accessing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pc_q         <= '0;
            ifReq_q      <= 1'b0;
            ifInst_q     <= NOP_INST;
            rdata_q      <= '0;
            timeoutErr_q <= 1'b0;
            waitCnt_q    <= '0;
            memReq_q     <= 1'b0;
            memAddr_q    <= '0;
            memWdata_q   <= '0;
            memRead_q    <= '0;
            memWrite_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    pc_q      <= ifPc_i;
                    ifReq_q   <= ifReq_i;
                    waitCnt_q <= '0;
                    if (dop) begin
                        state_q    <= D_ACC;
                        memReq_q   <= 1'b1;
                        memAddr_q  <= dmemAddr_i;
                        memWdata_q <= dmemWdata_i;
                        memRead_q  <= dmemRead_i;
                        memWrite_q <= dmemWrite_i;
                    end else if (ifReq_i) begin
                        state_q    <= I_ACC;
                        memReq_q   <= 1'b1;
                        memAddr_q  <= ifPc_i;
                        memWdata_q <= '0;
                        memRead_q  <= FETCH_READ;
                        memWrite_q <= '0;
                    end
                end

                D_ACC: begin
                    if (memAck_i || expired) begin
                        // An ACK on the expiry edge wins over the watchdog.
                        if (memAck_i) begin
                            if (memRead_q[3]) begin
                                rdata_q <= memRdata_i;
                            end
                        end else begin
                            rdata_q      <= '0;
                            timeoutErr_q <= 1'b1;
                        end
                        waitCnt_q <= '0;
                        if (ifReq_q) begin
                            state_q    <= I_ACC;
                            memReq_q   <= 1'b1;
                            memAddr_q  <= pc_q;
                            memWdata_q <= '0;
                            memRead_q  <= FETCH_READ;
                            memWrite_q <= '0;
                        end else begin
                            state_q    <= DONE;
                            memReq_q   <= 1'b0;
                            memAddr_q  <= '0;
                            memWdata_q <= '0;
                            memRead_q  <= '0;
                            memWrite_q <= '0;
                        end
                    end else begin
                        waitCnt_q <= waitCnt_q + 16'd1;
                    end
                end

                I_ACC: begin
                    if (memAck_i || expired) begin
                        if (memAck_i) begin
                            ifInst_q <= memRdata_i;
                        end else begin
                            ifInst_q     <= NOP_INST;
                            timeoutErr_q <= 1'b1;
                        end
                        waitCnt_q  <= '0;
                        state_q    <= DONE;
                        memReq_q   <= 1'b0;
                        memAddr_q  <= '0;
                        memWdata_q <= '0;
                        memRead_q  <= '0;
                        memWrite_q <= '0;
                    end else begin
                        waitCnt_q <= waitCnt_q + 16'd1;
                    end
                end

                DONE: begin
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // The stall must be visible in IDLE before the access starts, so it looks at live requests there.
    always_comb begin
        busyWait_o = 1'b0;
        case (state_q)
            IDLE:    busyWait_o = dop | ifReq_i;
            D_ACC:   busyWait_o = 1'b1;
            I_ACC:   busyWait_o = 1'b1;
            default: busyWait_o = 1'b0;
        endcase
    end

    assign ifInst_o     = ifInst_q;
    assign dmemRdata_o  = rdata_q;
    assign timeoutErr_o = timeoutErr_q;
    assign memReq_o     = memReq_q;
    assign memAddr_o    = memAddr_q;
    assign memWdata_o   = memWdata_q;
    assign memRead_o    = memRead_q;
    assign memWrite_o   = memWrite_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, load, store with waits, watchdog expiry and race, and reset mid-access.
// The watchdog limit is shortened to 4 cycles so expiry can be reached quickly.
module tb_mem_arbiter;

    localparam int          MAX_WAIT = 4;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic [31:0] ifPc;
    logic        ifReq;
    logic [31:0] ifInst;
    logic [31:0] dmemAddr;
    logic [31:0] dmemWdata;
    logic [3:0]  dmemRead;
    logic [2:0]  dmemWrite;
    logic [31:0] dmemRdata;
    logic        busyWait;
    logic        memReq;
    logic [31:0] memAddr;
    logic [31:0] memWdata;
    logic [3:0]  memRead;
    logic [2:0]  memWrite;
    logic [31:0] memRdata;
    logic        memAck;
    logic        timeoutErr;

    int checks = 0;
    int errors = 0;

    logic [5:0] busyPat;
    logic [5:0] reqPat;

    mem_arbiter #(
        .MAX_WAIT(MAX_WAIT),
        .NOP_INST(NOP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ifPc_i      (ifPc),
        .ifReq_i     (ifReq),
        .ifInst_o    (ifInst),
        .dmemAddr_i  (dmemAddr),
        .dmemWdata_i (dmemWdata),
        .dmemRead_i  (dmemRead),
        .dmemWrite_i (dmemWrite),
        .dmemRdata_o (dmemRdata),
        .busyWait_o  (busyWait),
        .memReq_o    (memReq),
        .memAddr_o   (memAddr),
        .memWdata_o  (memWdata),
        .memRead_o   (memRead),
        .memWrite_o  (memWrite),
        .memRdata_i  (memRdata),
        .memAck_i    (memAck),
        .timeoutErr_o(timeoutErr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%08h expected=%08h", tag, observed, expected);
        end
    endtask

    // Memory response presented for the coming rising edge, then sample 1 time unit after it.
    task automatic applyStimulus(input logic ack, input logic [31:0] rdata);
        memAck   = ack;
        memRdata = rdata;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    initial begin
        rst_n     = 1'b0;
        ifPc      = 32'h0;
        ifReq     = 1'b1;
        dmemAddr  = 32'h0;
        dmemWdata = 32'h0;
        dmemRead  = 4'b0000;
        dmemWrite = 3'b000;
        memRdata  = 32'h0;
        memAck    = 1'b0;
        busyPat   = 6'b011011;
        reqPat    = 6'b010010;

        $display("[TB] reset state");
        applyStimulus(1'b0, 32'h0);
        applyStimulus(1'b0, 32'h0);
        checkOutput("rst_ifInst", ifInst, NOP);
        checkOutput("rst_dmemRdata", dmemRdata, 32'h0);
        checkOutput("rst_timeoutErr", 32'(timeoutErr), 32'd0);
        checkOutput("rst_memReq", 32'(memReq), 32'd0);
        checkOutput("rst_memAddr", memAddr, 32'h0);
        rst_n = 1'b1;

        $display("[TB] fetch only");
        ifPc = 32'h40;
        checkOutput("f_idle_busy", 32'(busyWait), 32'd1);
        applyStimulus(1'b1, 32'h0050_0093);
        checkOutput("f_iacc_req", 32'(memReq), 32'd1);
        checkOutput("f_iacc_addr", memAddr, 32'h40);
        checkOutput("f_iacc_read", 32'(memRead), 32'hA);
        checkOutput("f_iacc_write", 32'(memWrite), 32'd0);
        applyStimulus(1'b1, 32'h0050_0093);
        checkOutput("f_done_inst", ifInst, 32'h0050_0093);
        checkOutput("f_done_busy", 32'(busyWait), 32'd0);
        checkOutput("f_done_req", 32'(memReq), 32'd0);
        applyStimulus(1'b1, 32'h0050_0093);
        for (int i = 0; i < 6; i++) begin
            checkOutput($sformatf("f_period_busy%0d", i), 32'(busyWait), 32'(busyPat[i]));
            checkOutput($sformatf("f_period_req%0d", i), 32'(memReq), 32'(reqPat[i]));
            applyStimulus(1'b1, 32'h0050_0093);
        end

        $display("[TB] load plus fetch");
        dmemRead = 4'b1010;
        dmemAddr = 32'h100;
        checkOutput("l_idle_busy", 32'(busyWait), 32'd1);
        applyStimulus(1'b1, 32'hDEAD_BEEF);
        checkOutput("l_dacc_req", 32'(memReq), 32'd1);
        checkOutput("l_dacc_addr", memAddr, 32'h100);
        checkOutput("l_dacc_read", 32'(memRead), 32'hA);
        applyStimulus(1'b1, 32'hDEAD_BEEF);
        checkOutput("l_rdata", dmemRdata, 32'hDEAD_BEEF);
        checkOutput("l_iacc_addr", memAddr, 32'h40);
        checkOutput("l_iacc_busy", 32'(busyWait), 32'd1);
        applyStimulus(1'b1, 32'h00A0_0113);
        checkOutput("l_done_inst", ifInst, 32'h00A0_0113);
        checkOutput("l_done_busy", 32'(busyWait), 32'd0);
        dmemRead = 4'b0000;
        applyStimulus(1'b1, 32'h00A0_0113);

        $display("[TB] store with two wait cycles");
        dmemWrite = 3'b110;
        dmemWdata = 32'h1234_5678;
        dmemAddr  = 32'h200;
        applyStimulus(1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("s_write%0d", i), 32'(memWrite), 32'h6);
            checkOutput($sformatf("s_wdata%0d", i), memWdata, 32'h1234_5678);
            checkOutput($sformatf("s_busy%0d", i), 32'(busyWait), 32'd1);
            if (i < 2) begin
                applyStimulus(1'b0, 32'h0);
            end
        end
        applyStimulus(1'b1, 32'hCAFE_F00D);
        checkOutput("s_rdata_kept", dmemRdata, 32'hDEAD_BEEF);
        checkOutput("s_iacc_write", 32'(memWrite), 32'd0);
        checkOutput("s_iacc_wdata", memWdata, 32'h0);
        applyStimulus(1'b1, 32'h0000_0513);
        checkOutput("s_done_inst", ifInst, 32'h0000_0513);
        checkOutput("s_done_busy", 32'(busyWait), 32'd0);
        checkOutput("s_no_timeout", 32'(timeoutErr), 32'd0);
        dmemWrite = 3'b000;
        applyStimulus(1'b1, 32'h0000_0513);

        $display("[TB] ack on the expiry edge");
        dmemRead = 4'b1010;
        dmemAddr = 32'h300;
        repeat (4) applyStimulus(1'b0, 32'h0);
        checkOutput("r_still_dacc", 32'(memReq), 32'd1);
        checkOutput("r_still_addr", memAddr, 32'h300);
        applyStimulus(1'b1, 32'h0BAD_CAFE);
        checkOutput("r_rdata", dmemRdata, 32'h0BAD_CAFE);
        checkOutput("r_no_timeout", 32'(timeoutErr), 32'd0);
        applyStimulus(1'b1, 32'h0010_0093);
        checkOutput("r_done_inst", ifInst, 32'h0010_0093);
        dmemRead = 4'b0000;
        applyStimulus(1'b1, 32'h0010_0093);

        $display("[TB] fetch timeout");
        repeat (4) applyStimulus(1'b0, 32'h0);
        checkOutput("t_iacc_req", 32'(memReq), 32'd1);
        checkOutput("t_iacc_noerr", 32'(timeoutErr), 32'd0);
        applyStimulus(1'b0, 32'h0);
        checkOutput("t_inst_nop", ifInst, NOP);
        checkOutput("t_err_set", 32'(timeoutErr), 32'd1);
        checkOutput("t_done_req", 32'(memReq), 32'd0);
        checkOutput("t_done_busy", 32'(busyWait), 32'd0);
        applyStimulus(1'b0, 32'h0);

        $display("[TB] data timeout");
        dmemRead = 4'b1010;
        dmemAddr = 32'h400;
        repeat (5) applyStimulus(1'b0, 32'h0);
        checkOutput("dt_rdata_zero", dmemRdata, 32'h0);
        checkOutput("dt_fetch_addr", memAddr, 32'h40);
        applyStimulus(1'b1, 32'h0020_0113);
        checkOutput("dt_done_inst", ifInst, 32'h0020_0113);
        dmemRead = 4'b0000;
        applyStimulus(1'b1, 32'h0020_0113);

        $display("[TB] sticky error over 20 steps");
        repeat (20) begin
            repeat (3) applyStimulus(1'b1, 32'h0030_0193);
        end
        checkOutput("st_err_sticky", 32'(timeoutErr), 32'd1);
        checkOutput("st_inst", ifInst, 32'h0030_0193);

        $display("[TB] reset during fetch");
        applyStimulus(1'b0, 32'h0);
        checkOutput("ra_req_before", 32'(memReq), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("ra_req_dropped", 32'(memReq), 32'd0);
        checkOutput("ra_inst_nop", ifInst, NOP);
        checkOutput("ra_err_clear", 32'(timeoutErr), 32'd0);
        checkOutput("ra_rdata_clear", dmemRdata, 32'h0);
        applyStimulus(1'b1, 32'h0);
        rst_n = 1'b1;
        #1;
        checkOutput("ra_busy_after", 32'(busyWait), 32'd1);
        checkOutput("ra_req_after", 32'(memReq), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares a single external memory port between the IF-stage instruction fetch and the MA-stage data access of the 5-stage RV32IM pipeline.
- Sequences at most one data access, then one fetch, per pipeline step.
- Generates the pipeline-wide BUSYWAIT stall that freezes the PC and all four pipeline registers until both accesses have completed.
- Includes a per-access timeout watchdog with a sticky error flag.

Parameters:
- MAX_WAIT, 255: cycles without MEM_ACK before an access is abandoned. Legal range 1..65535.
- NOP_INST, 32'h00000013: instruction returned on reset and on a fetch timeout.

Ports:
- CLK  input  1  Clock; all state changes on the rising edge.
- RST  input  1  Reset, asynchronous and active-low; state is cleared while RST=0.
- IF_PC  input  32  Fetch address from the PC.
- IF_REQ  input  1  Fetch request; the CPU ties it to 1.
- IF_INST  output  32  Latched instruction, feeds the IF/ID register.
- DMEM_ADDR  input  32  Data address (ALU result in MA).
- DMEM_WDATA  input  32  Store data.
- DMEM_READ  input  4  Load control: bit3 = enable, bits[2:0] = funct3.
- DMEM_WRITE  input  3  Store control: bit2 = enable, bits[1:0] = size.
- DMEM_RDATA  output  32  Latched load data, feeds the MA/WB register.
- BUSYWAIT  output  1  Pipeline stall.
- MEM_REQ  output  1  External memory request.
- MEM_ADDR  output  32  Address to memory.
- MEM_WDATA  output  32  Write data to memory.
- MEM_READ  output  4  Read control to memory; same encoding as DMEM_READ.
- MEM_WRITE  output  3  Write control to memory; same encoding as DMEM_WRITE.
- MEM_RDATA  input  32  Read data from memory.
- MEM_ACK  input  1  Memory completion; valid only while MEM_REQ=1.
- TIMEOUT_ERR  output  1  Sticky watchdog flag.

Behaviour:
- Definitions:
  - DOP = DMEM_READ[3] | DMEM_WRITE[2].
  - States: IDLE, D_ACC, I_ACC, DONE.
- Reset (RST=0, asynchronous):
  - state=IDLE, IF_INST=NOP_INST, DMEM_RDATA=0, TIMEOUT_ERR=0, wait counter=0.
  - All latched request registers cleared, so MEM_REQ/MEM_ADDR/MEM_WDATA/MEM_READ/MEM_WRITE=0.
  - Reset during D_ACC or I_ACC drops MEM_REQ immediately. No completion is reported and no data is latched.
- IDLE:
  - Latch IF_PC, DMEM_ADDR, DMEM_WDATA, DMEM_READ and DMEM_WRITE every cycle.
  - DOP=1 -> D_ACC. Else IF_REQ=1 -> I_ACC. Else stay in IDLE.
- D_ACC:
  - MEM_REQ=1; MEM_* driven from the latched data request.
  - On MEM_ACK=1 at an edge: if the latched READ[3]=1, DMEM_RDATA<=MEM_RDATA.
  - Then -> I_ACC if the latched IF_REQ=1, else -> DONE.
- I_ACC:
  - MEM_REQ=1, MEM_ADDR=latched PC, MEM_READ=4'b1010 (word load), MEM_WRITE=0, MEM_WDATA=0.
  - On MEM_ACK=1: IF_INST<=MEM_RDATA, -> DONE.
- DONE: -> IDLE unconditionally. This is the single cycle in which the pipeline advances.
- MEM_REQ=0 in IDLE and DONE. MEM_ACK is ignored in those states.
- BUSYWAIT (combinational):
  - 1 in D_ACC and I_ACC.
  - 1 in IDLE when (DOP | IF_REQ).
  - 0 in DONE, and 0 in IDLE with no request.
- Latency with MEM_ACK high in the first access cycle:
  - Fetch only: 3 cycles per step (IDLE, I_ACC, DONE).
  - Fetch plus data: 4 cycles per step.
  - Each wait cycle without MEM_ACK adds one cycle.
- Watchdog:
  - The counter clears on entry to D_ACC or I_ACC and increments each cycle without MEM_ACK.
  - When the counter reaches MAX_WAIT-1 and MEM_ACK=0, the access is abandoned at that edge:
    - D_ACC: DMEM_RDATA<=0, transition as if acked.
    - I_ACC: IF_INST<=NOP_INST, -> DONE.
  - TIMEOUT_ERR<=1 on abandonment and is cleared only by reset.
  - An ACK arriving on the expiry edge wins; no error is raised.
- Stores: DMEM_RDATA is unchanged after a store.
- Simultaneous read and write enables: the request is passed through unmodified. Arbitration order is data first, then fetch, every step; there is no starvation because both are served each step.

Test Plan:
- Reset: RST=0 mid-I_ACC with MEM_REQ=1 -> MEM_REQ=0 the same cycle, IF_INST=32'h00000013, BUSYWAIT=1 after release (IF_REQ=1).
- Fetch only: IF_PC=0x40, memory acks in the first cycle with 0x00500093 -> MEM_REQ high for one cycle with MEM_READ=4'b1010, IF_INST=0x00500093, BUSYWAIT low exactly one cycle in every 3.
- Load plus fetch: DMEM_READ=4'b1010, DMEM_ADDR=0x100, ack data 0xDEADBEEF -> data access issued before fetch, DMEM_RDATA=0xDEADBEEF, BUSYWAIT period is 4 cycles.
- Store: DMEM_WRITE=3'b110, DMEM_WDATA=0x12345678, memory inserts 2 wait cycles -> MEM_WRITE/MEM_WDATA held stable for 3 cycles, DMEM_RDATA unchanged, step takes 6 cycles.
- Timeout: MAX_WAIT=4, no ACK in I_ACC -> abandoned after 4 cycles, IF_INST=NOP_INST, TIMEOUT_ERR=1 and still set 20 steps later.
- Race: ACK on the expiry edge -> data latched, TIMEOUT_ERR stays 0.
